// File: rtl/mem_master_pkg.sv
// Shared definitions for the memory initiator and the 4096x16 memory block.
package mem_master_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/mem_master.sv
// Memory initiator: takes single-word requests from the control unit and
// runs a setup / strobe / recover sequence on the memory lines, so address
// and data are stable around every strobe. All outputs are registered.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_indata,
  input  logic [DATA_W-1:0] mem_outdata
);

  // Strobe length minus one; the counter hits zero on the last strobe cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

  state_t           state;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  // Access sequencer: every output is a register written only here, so the
  // strobes are glitch-free and an async reset drops them immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      cnt         <= '0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_indata  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Request inputs only matter here; address/data keep last values.
          if (cpu_req) begin
            mem_address <= cpu_addr;
            mem_indata  <= cpu_wdata;
            we_q        <= cpu_we;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          cnt       <= CNT_LOAD;
          mem_read  <= ~we_q;
          mem_write <= we_q;
          state     <= STROBE;
        end
        STROBE: begin
          if (cnt == '0) begin
            if (!we_q) cpu_rdata <= mem_outdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= 1'b1;
            state     <= RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          // A held request is picked up on the following IDLE edge.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
